// File: rtl/mux_channel_sequencer.sv
// mux_channel_sequencer: six-entry channel register bank plus a select sequencer
// that scans enabled channels in ascending order under a valid/ready handshake.
module mux_channel_sequencer #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cont,
  input  logic              start,
  input  logic              stop,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] data5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned IDX_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] SEL_IDLE = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [SEL_W-1:0]  sel_d;
  logic              valid_d, busy_d, done_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              hs, wr_bad, wr_ok;
  logic [IDX_W-1:0]  nxt, wrap;
  logic [DATA_W-1:0] regs_q [NUM_CH];

  // Lowest set bit of mask at or above lo; MSB of result flags that one was found.
  function automatic logic [IDX_W-1:0] first_from(input logic [NUM_CH-1:0] mask,
                                                  input logic [IDX_W-1:0]  lo);
    logic [IDX_W-1:0] r;
    r = {1'b0, SEL_IDLE};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= lo)) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  // Write acceptance: offered channel data is frozen until its handshake.
  always_comb begin
    wr_bad = wr_en && ((wr_ch >= SEL_W'(NUM_CH)) || (out_valid && (wr_ch == sel)));
    wr_ok  = wr_en && !wr_bad;
  end

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    sel_d   = sel;
    valid_d = out_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = xfer_cnt;
    hs      = out_valid && out_ready;
    nxt     = first_from(en_q, {1'b0, sel} + IDX_W'(1));
    wrap    = first_from(ch_en, '0);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (|ch_en) begin
            state_d = ST_SCAN;
            en_d    = ch_en;
            sel_d   = wrap[SEL_W-1:0];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (hs) cnt_d = xfer_cnt + CNT_W'(1);
        if (stop || (hs && !nxt[SEL_W] && !(cont && (|ch_en)))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          sel_d   = SEL_IDLE;
        end else if (hs) begin
          if (nxt[SEL_W]) begin
            sel_d = nxt[SEL_W-1:0];
          end else begin
            en_d  = ch_en;
            sel_d = wrap[SEL_W-1:0];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        sel_d   = SEL_IDLE;
      end
    endcase
  end

  // State, output and channel register bank update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      sel       <= SEL_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      xfer_cnt  <= '0;
      for (int i = 0; i < NUM_CH; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      sel       <= sel_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      wr_err    <= wr_bad;
      xfer_cnt  <= cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok && (wr_ch == SEL_W'(i))) regs_q[i] <= wr_data;
      end
    end
  end

  assign data0 = regs_q[0];
  assign data1 = regs_q[1];
  assign data2 = regs_q[2];
  assign data3 = regs_q[3];
  assign data4 = regs_q[4];
  assign data5 = regs_q[5];

endmodule

// File: tb/tb_mux_channel_sequencer.sv
// Testbench for mux_channel_sequencer: vector table, directed corner sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_mux_channel_sequencer;

  logic       clk = 1'b0;
  logic       reset, wr_en, cont, start, stop, out_ready;
  logic [2:0] wr_ch;
  logic [3:0] wr_data;
  logic [5:0] ch_en;
  logic       wr_err, out_valid, busy, done;
  logic [2:0] sel;
  logic [3:0] data0, data1, data2, data3, data4, data5;
  logic [7:0] xfer_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux_channel_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_err(wr_err), .ch_en(ch_en), .cont(cont), .start(start), .stop(stop),
    .sel(sel), .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .xfer_cnt(xfer_cnt)
  );

  // Behavioural model: phase 0 idle, 1 scanning, 2 done pulse.
  int       m_phase;
  bit [5:0] m_mask;
  int       m_sel;
  int       m_data [6];
  int       m_cnt;
  bit       m_err;

  typedef struct {
    logic       we;
    logic [2:0] wch;
    logic [3:0] wd;
    logic [5:0] en;
    logic       cm;
    logic       st;
    logic       sp;
    logic       rdy;
    logic [2:0] e_sel;
    logic       e_valid;
    logic       e_done;
    logic       e_err;
    logic [7:0] e_cnt;
    logic [3:0] e_mux;
  } vec_t;

  vec_t tbl [$];

  function automatic int first_from(input bit [5:0] mask, input int lo);
    for (int i = lo; i < 6; i++) if (mask[i]) return i;
    return 6;
  endfunction

  function automatic int mux_out();
    case (sel)
      3'd0: return int'(data0);
      3'd1: return int'(data1);
      3'd2: return int'(data2);
      3'd3: return int'(data3);
      3'd4: return int'(data4);
      3'd5: return int'(data5);
      default: return 0;
    endcase
  endfunction

  function automatic int data_vec();
    return int'({data5, data4, data3, data2, data1, data0});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_step();
    bit v, hs, err;
    int n;
    if (reset) begin
      m_phase = 0; m_mask = '0; m_sel = 7; m_cnt = 0; m_err = 1'b0;
      for (int i = 0; i < 6; i++) m_data[i] = 0;
      return;
    end
    v   = (m_phase == 1);
    hs  = v && out_ready;
    err = wr_en && ((int'(wr_ch) > 5) || (v && int'(wr_ch) == m_sel));
    if (wr_en && !err) m_data[int'(wr_ch)] = int'(wr_data);
    m_err = err;
    case (m_phase)
      0: if (start) begin
        m_cnt = 0;
        if (ch_en == 6'd0) m_phase = 2;
        else begin
          m_mask = ch_en; m_sel = first_from(ch_en, 0); m_phase = 1;
        end
      end
      1: begin
        if (hs) m_cnt = (m_cnt + 1) % 256;
        if (stop) m_phase = 2;
        else if (hs) begin
          n = first_from(m_mask, m_sel + 1);
          if (n < 6) m_sel = n;
          else if (cont && ch_en != 6'd0) begin
            m_mask = ch_en; m_sel = first_from(ch_en, 0);
          end else m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic model_compare();
    int e_sel, e_dat;
    bit v;
    v     = (m_phase == 1);
    e_sel = v ? m_sel : 7;
    e_dat = 0;
    for (int i = 0; i < 6; i++) e_dat = e_dat | (m_data[i] << (4 * i));
    check("model_ctrl", int'({sel, out_valid, busy, done, wr_err}),
          (e_sel << 4) | (int'(v) << 3) | (int'(v) << 2) | (int'(m_phase == 2) << 1) | int'(m_err));
    check("model_xfer_cnt", int'(xfer_cnt), m_cnt);
    check("model_data", data_vec(), e_dat);
  endtask

  // One clock: advance the model on current inputs, then compare after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    model_compare();
  endtask

  function automatic vec_t mk(input int we, input int wch, input int wd, input int en,
                              input int cm, input int st, input int sp, input int rdy,
                              input int es, input int ev, input int ed, input int ee,
                              input int ec, input int em);
    vec_t r;
    r.we = 1'(we); r.wch = 3'(wch); r.wd = 4'(wd); r.en = 6'(en); r.cm = 1'(cm);
    r.st = 1'(st); r.sp = 1'(sp); r.rdy = 1'(rdy); r.e_sel = 3'(es); r.e_valid = 1'(ev);
    r.e_done = 1'(ed); r.e_err = 1'(ee); r.e_cnt = 8'(ec); r.e_mux = 4'(em);
    return r;
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0; wr_ch = 3'd0; wr_data = 4'd0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; idle_inputs(); ch_en = 6'd0; cont = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    check("reset_sel", int'(sel), 7);
    check("reset_flags", int'({out_valid, busy, done, wr_err}), 0);
    check("reset_cnt_data", int'(xfer_cnt) + data_vec(), 0);
    reset = 1'b0;

    // Full single pass, sparse pass and bad-index writes.
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, i, i + 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h3f, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1));
    for (int k = 1; k < 6; k++) tbl.push_back(mk(0, 0, 0, 'h3f, 0, 0, 0, 1, k, 1, 0, 0, k, k + 1));
    tbl.push_back(mk(0, 0, 0, 'h3f, 0, 0, 0, 1, 7, 0, 1, 0, 6, 0));
    tbl.push_back(mk(0, 0, 0, 'h3f, 0, 1, 0, 1, 7, 0, 0, 0, 6, 0));
    tbl.push_back(mk(0, 0, 0, 'h25, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 'h25, 0, 0, 0, 1, 2, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 'h25, 0, 0, 0, 1, 5, 1, 0, 0, 2, 6));
    tbl.push_back(mk(0, 0, 0, 'h25, 0, 0, 0, 1, 7, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 'h25, 0, 0, 0, 1, 7, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 6, 9, 0, 0, 0, 0, 0, 7, 0, 0, 1, 3, 0));
    tbl.push_back(mk(1, 7, 9, 0, 0, 0, 0, 0, 7, 0, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 3, 0));
    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_ch = tbl[i].wch; wr_data = tbl[i].wd; ch_en = tbl[i].en;
      cont = tbl[i].cm; start = tbl[i].st; stop = tbl[i].sp; out_ready = tbl[i].rdy;
      cyc();
      check($sformatf("vec%0d_sel", i), int'(sel), int'(tbl[i].e_sel));
      check($sformatf("vec%0d_flags", i), int'({out_valid, busy, done, wr_err}),
            int'({tbl[i].e_valid, tbl[i].e_valid, tbl[i].e_done, tbl[i].e_err}));
      check($sformatf("vec%0d_cnt", i), int'(xfer_cnt), int'(tbl[i].e_cnt));
      check($sformatf("vec%0d_mux", i), mux_out(), int'(tbl[i].e_mux));
    end
    idle_inputs();

    // Stall on channel 2 with writes to the offered and a neighbouring channel.
    ch_en = 6'h3f; cont = 1'b0; start = 1'b1; out_ready = 1'b0;
    cyc();
    start = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    check("stall_reach_sel", int'(sel), 2);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_en = (k < 2); wr_ch = (k == 0) ? 3'd2 : 3'd3; wr_data = (k == 0) ? 4'hf : 4'ha;
      cyc();
      check("stall_sel_valid", int'({sel, out_valid}), (2 << 1) | 1);
      check("stall_cnt", int'(xfer_cnt), 2);
      if (k == 0) check("stall_wr_err_ch2", int'({wr_err, data2}), 'h13);
      if (k == 1) check("stall_wr_ch3", int'({wr_err, data3, data2}), 'h0a3);
    end
    idle_inputs(); out_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("stall_done", int'({done, sel, xfer_cnt}), (1 << 11) | (7 << 8) | 6);
    cyc();

    // Continuous wrap over channels 0 and 1, then stop during a handshake.
    ch_en = 6'h03; cont = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("cont_sel_seq", int'(sel), k % 2);
      cyc();
    end
    check("cont_pre_stop", int'({sel, out_valid, xfer_cnt}), (1 << 9) | (1 << 8) | 5);
    stop = 1'b1;
    cyc();
    check("cont_stop_done", int'({done, out_valid, busy, sel, xfer_cnt}), (1 << 13) | (7 << 8) | 6);
    stop = 1'b0; cont = 1'b0;
    cyc();
    check("cont_idle", int'({done, out_valid, busy, sel}), 7);

    // Empty mask start and out-of-range write index.
    ch_en = 6'h00; start = 1'b1;
    cyc();
    check("empty_done", int'({done, out_valid, busy, xfer_cnt}), 'h400);
    start = 1'b0;
    cyc();
    check("empty_after", int'({done, out_valid}), 0);
    wr_en = 1'b1; wr_ch = 3'd7; wr_data = 4'h5;
    cyc();
    check("bad_idx_err", int'(wr_err), 1);
    wr_en = 1'b0;
    cyc();
    check("bad_idx_clear", int'(wr_err), 0);

    // Reset in the middle of a scan.
    ch_en = 6'h3f; cont = 1'b1; start = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    check("midrst_ctrl", int'({sel, out_valid, busy, done}), 7 << 3);
    check("midrst_data", data_vec(), 0);
    reset = 1'b0;
    cyc();
    check("midrst_no_done", int'(done), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_ch     = 3'($urandom_range(0, 7));
      wr_data   = 4'($urandom);
      ch_en     = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
      cont      = ($urandom_range(0, 1) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
